// File: rtl/seq_detect_fsm.sv
// Serial pattern detector. Tracks the longest matched prefix of PATTERN (MSB first),
// raises a registered one-cycle match flag on completion and keeps a saturating match count.
// Transitions come from a table built at elaboration, KMP style.
module seq_detect_fsm #(
  parameter int unsigned W       = 4,
  parameter logic [W-1:0] PATTERN = 4'b1101,
  parameter bit          OVERLAP = 1'b1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in,
  input  logic                   in_valid,
  input  logic                   clear_cnt,
  output logic                   match,
  output logic [CNT_W-1:0]       match_cnt,
  output logic [$clog2(W+1)-1:0] progress
);

  localparam int unsigned PW = $clog2(W + 1);

  // Longest proper prefix of PATTERN that is also a suffix of it.
  function automatic int unsigned border_len();
    int unsigned best;
    logic        ok;
    best = 0;
    for (int unsigned j = 1; j < W; j++) begin
      ok = 1'b1;
      for (int unsigned i = 0; i < j; i++) begin
        if (PATTERN[W-1-i] != PATTERN[j-1-i]) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

  // Longest prefix of PATTERN that is a suffix of (first k pattern bits, then bit b).
  function automatic int unsigned ext_len(int unsigned k, int unsigned b);
    int unsigned best;
    int unsigned t;
    logic        ok;
    logic        sb;
    best = 0;
    for (int unsigned j = 1; j <= W; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < j; i++) begin
          t  = k + 1 - j + i;
          sb = (t < k) ? PATTERN[W-1-t] : (b != 0);
          if (sb != PATTERN[W-1-i]) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  localparam int unsigned Border = border_len();

  logic [PW-1:0]    tbl_state [2][W];
  logic             tbl_hit   [2][W];

  logic [PW-1:0]    state_q, state_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    step_state;
  logic             step_hit;

  for (genvar k = 0; k < W; k++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int unsigned Len     = ext_len(k, b);
      localparam int unsigned NextLen = (Len == W) ? (OVERLAP ? Border : 0) : Len;
      assign tbl_state[b][k] = PW'(NextLen);
      assign tbl_hit[b][k]   = (Len == W);
    end
  end

  // State, match flag and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state from the transition table; counter clear still counts a same-cycle match.
  always_comb begin
    step_state = '0;
    step_hit   = 1'b0;
    for (int unsigned k = 0; k < W; k++) begin
      if (state_q == PW'(k)) begin
        step_state = tbl_state[in][k];
        step_hit   = tbl_hit[in][k];
      end
    end

    state_d = state_q;
    match_d = 1'b0;
    if (in_valid) begin
      state_d = step_state;
      match_d = step_hit;
    end

    cnt_d = cnt_q;
    if (clear_cnt) begin
      cnt_d = match_d ? CNT_W'(1) : '0;
    end else if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    match     = match_q;
    match_cnt = cnt_q;
    progress  = state_q;
  end

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Scoreboard bench for seq_detect_fsm: five parameterisations share one stimulus stream;
// a history-based reference model predicts every cycle and a negedge monitor compares.
module tb_seq_detect_fsm;

  localparam int NI = 5;
  localparam int unsigned MW [NI] = '{4, 4, 4, 1, 6};
  localparam int unsigned MP [NI] = '{32'hD, 32'hD, 32'hF, 32'h1, 32'h2D};
  localparam int unsigned MO [NI] = '{1, 0, 1, 1, 1};
  localparam int unsigned MC [NI] = '{8, 8, 8, 2, 3};

  typedef struct packed {
    logic [NI-1:0]       m;
    logic [NI-1:0][31:0] c;
    logic [NI-1:0][3:0]  p;
  } exp_t;

  logic clk = 1'b0;
  logic reset, in, in_valid, clear_cnt;

  logic       m0, m1, m2, m3, m4;
  logic [7:0] c0, c1, c2;
  logic [1:0] c3;
  logic [2:0] c4;
  logic [2:0] p0, p1, p2, p4;
  logic [0:0] p3;

  logic        act_m [NI];
  logic [31:0] act_c [NI];
  logic [3:0]  act_p [NI];

  exp_t        exp_q [$];
  int unsigned hist [NI];
  int unsigned hlen [NI];
  int unsigned cnt  [NI];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  seq_detect_fsm #(.W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u_dut0 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .clear_cnt(clear_cnt),
    .match(m0), .match_cnt(c0), .progress(p0));
  seq_detect_fsm #(.W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) u_dut1 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .clear_cnt(clear_cnt),
    .match(m1), .match_cnt(c1), .progress(p1));
  seq_detect_fsm #(.W(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(8)) u_dut2 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .clear_cnt(clear_cnt),
    .match(m2), .match_cnt(c2), .progress(p2));
  seq_detect_fsm #(.W(1), .PATTERN(1'b1), .OVERLAP(1'b1), .CNT_W(2)) u_dut3 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .clear_cnt(clear_cnt),
    .match(m3), .match_cnt(c3), .progress(p3));
  seq_detect_fsm #(.W(6), .PATTERN(6'b101101), .OVERLAP(1'b1), .CNT_W(3)) u_dut4 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .clear_cnt(clear_cnt),
    .match(m4), .match_cnt(c4), .progress(p4));

  assign act_m[0] = m0;
  assign act_m[1] = m1;
  assign act_m[2] = m2;
  assign act_m[3] = m3;
  assign act_m[4] = m4;
  assign act_c[0] = 32'(c0);
  assign act_c[1] = 32'(c1);
  assign act_c[2] = 32'(c2);
  assign act_c[3] = 32'(c3);
  assign act_c[4] = 32'(c4);
  assign act_p[0] = 4'(p0);
  assign act_p[1] = 4'(p1);
  assign act_p[2] = 4'(p2);
  assign act_p[3] = 4'(p3);
  assign act_p[4] = 4'(p4);

  function automatic int unsigned mask(int unsigned j);
    return (j >= 32) ? 32'hFFFF_FFFF : ((32'd1 << j) - 32'd1);
  endfunction

  // Longest prefix (shorter than the pattern) that ends the consumed history.
  function automatic int unsigned prefix_len(int i);
    int unsigned best;
    best = 0;
    for (int unsigned j = 1; j < MW[i]; j++) begin
      if (j <= hlen[i] && (hist[i] & mask(j)) == (MP[i] >> (MW[i] - j))) best = j;
    end
    return best;
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s u%0d at %0t: got %0d, expected %0d", name, i, $time, act, expv);
    end
  endtask

  // Drive one cycle of inputs, advance the model, queue the expected post-edge outputs.
  task automatic step(input logic r, input logic v, input logic b, input logic c);
    exp_t e;
    logic m;
    reset = r; in_valid = v; in = b; clear_cnt = c;
    for (int i = 0; i < NI; i++) begin
      m = 1'b0;
      if (r) begin
        hist[i] = 0; hlen[i] = 0; cnt[i] = 0;
      end else begin
        if (v) begin
          hist[i] = (hist[i] << 1) | 32'(b);
          if (hlen[i] < 16) hlen[i]++;
          if (hlen[i] >= MW[i] && (hist[i] & mask(MW[i])) == MP[i]) m = 1'b1;
          if (m && MO[i] == 0) begin
            hist[i] = 0; hlen[i] = 0;
          end
        end
        if (c) cnt[i] = m ? 1 : 0;
        else if (m && cnt[i] < mask(MC[i])) cnt[i]++;
      end
      e.m[i] = m;
      e.c[i] = cnt[i];
      e.p[i] = 4'(prefix_len(i));
    end
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  // Monitor: one expectation per clock, compared away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int i = 0; i < NI; i++) begin
        check("match", i, 32'(act_m[i]), 32'(e.m[i]));
        check("match_cnt", i, act_c[i], e.c[i]);
        check("progress", i, 32'(act_p[i]), 32'(e.p[i]));
      end
    end
  end

  initial begin
    logic [6:0] s;
    logic [3:0] s4;
    reset = 1'b1; in = 1'b0; in_valid = 1'b0; clear_cnt = 1'b0;
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);  // reset dominates a valid bit and a clear

    // Basic overlapping / non-overlapping stream.
    s = 7'b1101101;
    for (int i = 6; i >= 0; i--) step(0, 1, s[i], 0);
    check("plan_cnt_ovl", 0, act_c[0], 32'd2);
    check("plan_prog_ovl", 0, 32'(act_p[0]), 32'd1);
    check("plan_cnt_novl", 1, act_c[1], 32'd1);
    check("plan_prog_novl", 1, 32'(act_p[1]), 32'd1);

    // Reset discards a partial match.
    step(1, 0, 0, 0);
    step(0, 1, 1, 0); step(0, 1, 1, 0); step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    check("rst_match", 0, 32'(act_m[0]), 32'd0);
    check("rst_cnt", 0, act_c[0], 32'd0);
    check("rst_prog", 0, 32'(act_p[0]), 32'd0);
    step(0, 1, 1, 0);
    check("after_rst_prog", 0, 32'(act_p[0]), 32'd1);
    check("after_rst_match", 0, 32'(act_m[0]), 32'd0);

    // Gaps of invalid cycles with junk data between pattern bits.
    step(1, 0, 0, 0);
    s4 = 4'b1101;
    for (int i = 3; i >= 0; i--) begin
      step(0, 1, s4[i], 0);
      for (int g = 0; g < 3; g++) step(0, 0, 1'($urandom_range(0, 1)), 0);
    end
    check("gap_cnt", 0, act_c[0], 32'd1);

    // Six ones: back-to-back matches on the all-ones pattern.
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0);
    check("ones_cnt", 2, act_c[2], 32'd3);
    check("ones_prog", 2, 32'(act_p[2]), 32'd3);

    // Saturation of a 2-bit counter, then clear with a coincident match.
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0);
    check("sat_cnt", 3, act_c[3], 32'd3);
    step(0, 1, 1, 1);
    check("clr_match_cnt", 3, act_c[3], 32'd1);
    step(0, 0, 0, 1);
    check("clr_idle_cnt", 3, act_c[3], 32'd0);

    // Random traffic: uniform bits, then ones-biased bits.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8),
           (n < 1500) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 49) == 0));
    end

    step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("queue_drain", 0, 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
